// File: rtl/linear_layer_fifo_pkg.sv
// Shared constants and elaboration helpers for the Linear_Layer stream FIFOs.
package linear_layer_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_DEPTH      = 16;
    localparam int DEFAULT_AF_MARGIN  = 2;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    localparam int DEFAULT_ADDR_WIDTH = clog2(DEFAULT_DEPTH);

    function automatic bit addr_width_ok(input int depth, input int addr_width);
        return addr_width == clog2(depth);
    endfunction

endpackage

// File: rtl/linear_layer_srl_fifo_shiftreg.sv
// SRL-inferable storage: unreset shift chain with an addressed read tap.
module linear_layer_srl_fifo_shiftreg
    import linear_layer_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    assign mem_d[0] = din;

    genvar gi;
    generate
        for (gi = 1; gi < DEPTH; gi++) begin : g_shift
            assign mem_d[gi] = mem_q[gi-1];
        end
    endgenerate

    // No reset here, so the chain maps onto shift-register primitives.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q <= mem_d;
        end
    end

    assign dout = mem_q[addr];

endmodule

// File: rtl/linear_layer_srl_fifo.sv
// ap_fifo-style SRL FIFO with occupancy and almost-full flag.
// Define LINEAR_LAYER_SRL_FIFO_OUTREG_EN to add a one-entry output register.
module linear_layer_srl_fifo
    import linear_layer_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int AF_MARGIN  = DEFAULT_AF_MARGIN
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write_ce,
    input  logic                  if_write,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    output logic                  if_almost_full_n,
    input  logic                  if_read_ce,
    input  logic                  if_read,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   count
);

    generate
        if (!addr_width_ok(DEPTH, ADDR_WIDTH)) begin : g_bad_addr_width
            $error("linear_layer_srl_fifo: ADDR_WIDTH must equal clog2(DEPTH)");
        end
    endgenerate

    localparam int                AF_INT   = DEPTH - AF_MARGIN;
    localparam logic [ADDR_WIDTH:0] DEPTH_C  = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AF_LEVEL = AF_INT[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;
    logic                  push;
    logic                  pop;
    logic                  srl_pop;
    logic                  srl_nonempty;
    logic [ADDR_WIDTH-1:0] srl_addr;
    logic [DATA_WIDTH-1:0] srl_dout;

    assign srl_nonempty     = (count_q != '0);
    assign if_full_n        = (count_q != DEPTH_C);
    assign if_almost_full_n = (count_q < AF_LEVEL);
    assign push             = if_write_ce & if_write & if_full_n;
    assign count            = count_q;
    // Head sits at count-1; the low bits alone give that index for every legal count.
    assign srl_addr         = count_q[ADDR_WIDTH-1:0] - 1'b1;

    linear_layer_srl_fifo_shiftreg #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_shiftreg (
        .clk  (clk),
        .we   (push),
        .addr (srl_addr),
        .din  (if_din),
        .dout (srl_dout)
    );

    always_comb begin
        count_d = count_q;
        if (push && !srl_pop) begin
            count_d = count_q + 1'b1;
        end else if (srl_pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

`ifdef LINEAR_LAYER_SRL_FIFO_OUTREG_EN
    logic [DATA_WIDTH-1:0] dout_q;
    logic [DATA_WIDTH-1:0] dout_d;
    logic                  dout_vld_q;
    logic                  dout_vld_d;

    assign pop     = if_read_ce & if_read & dout_vld_q;
    // Refill the output slot whenever it is free or being drained this cycle.
    assign srl_pop = srl_nonempty & (~dout_vld_q | pop);

    always_comb begin
        dout_d     = dout_q;
        dout_vld_d = dout_vld_q;
        if (srl_pop) begin
            dout_d     = srl_dout;
            dout_vld_d = 1'b1;
        end else if (pop) begin
            dout_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            dout_q     <= dout_d;
            dout_vld_q <= dout_vld_d;
        end
    end

    assign if_empty_n = dout_vld_q;
    assign if_dout    = dout_q;
`else
    assign pop        = if_read_ce & if_read & srl_nonempty;
    assign srl_pop    = pop;
    assign if_empty_n = srl_nonempty;
    assign if_dout    = srl_dout;
`endif

endmodule

// File: tb/tb_linear_layer_srl_fifo.sv
// Self-checking bench: directed plus random traffic against a queue-based model.
module tb_linear_layer_srl_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int AFM   = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_write_ce;
    logic          if_write;
    logic [DW-1:0] if_din;
    logic          if_full_n;
    logic          if_almost_full_n;
    logic          if_read_ce;
    logic          if_read;
    logic [DW-1:0] if_dout;
    logic          if_empty_n;
    logic [AW:0]   count;

    always #5 clk = ~clk;

    linear_layer_srl_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .AF_MARGIN  (AFM)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .if_write_ce      (if_write_ce),
        .if_write         (if_write),
        .if_din           (if_din),
        .if_full_n        (if_full_n),
        .if_almost_full_n (if_almost_full_n),
        .if_read_ce       (if_read_ce),
        .if_read          (if_read),
        .if_dout          (if_dout),
        .if_empty_n       (if_empty_n),
        .count            (count)
    );

    int checks = 0;
    int errors = 0;

    // Reference: srl_q holds the SRL words oldest-first; ov/od model the optional output slot.
    logic [DW-1:0] srl_q[$];
    bit            ov;
    logic [DW-1:0] od;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int n;
        n = srl_q.size();
        chk("count", 32'(count), 32'(n));
        chk("full_n", 32'(if_full_n), 32'(n != DEPTH));
        chk("almost_full_n", 32'(if_almost_full_n), 32'(n < DEPTH - AFM));
`ifdef LINEAR_LAYER_SRL_FIFO_OUTREG_EN
        chk("empty_n", 32'(if_empty_n), 32'(ov));
        if (ov) chk("dout", if_dout, od);
`else
        chk("empty_n", 32'(if_empty_n), 32'(n != 0));
        if (n != 0) chk("dout", if_dout, srl_q[0]);
`endif
    endtask

    task automatic model_edge(input bit rst, input bit wce, input bit w, input bit rce,
                              input bit r, input logic [DW-1:0] d);
        bit do_push;
        bit do_pop;
        if (rst) begin
            srl_q.delete();
            ov = 1'b0;
            od = '0;
        end else begin
            do_push = wce && w && (srl_q.size() != DEPTH);
`ifdef LINEAR_LAYER_SRL_FIFO_OUTREG_EN
            do_pop = rce && r && ov;
            if (srl_q.size() != 0 && (!ov || do_pop)) begin
                od = srl_q.pop_front();
                ov = 1'b1;
            end else if (do_pop) begin
                ov = 1'b0;
            end
`else
            do_pop = rce && r && (srl_q.size() != 0);
            if (do_pop) void'(srl_q.pop_front());
`endif
            if (do_push) srl_q.push_back(d);
        end
    endtask

    task automatic cycle(input bit rst, input bit wce, input bit w, input bit rce,
                         input bit r, input logic [DW-1:0] d);
        reset       = rst;
        if_write_ce = wce;
        if_write    = w;
        if_read_ce  = rce;
        if_read     = r;
        if_din      = d;
        check_outputs();
        @(posedge clk);
        model_edge(rst, wce, w, rce, r, d);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        if_write_ce = 1'b0;
        if_write    = 1'b0;
        if_read_ce  = 1'b0;
        if_read     = 1'b0;
        if_din      = '0;
        ov          = 1'b0;
        od          = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then pops on an empty FIFO.
        cycle(1, 0, 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 1, '0);

        // Single word latency.
        cycle(0, 1, 1, 0, 0, 32'hA5);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 2; i++) cycle(0, 0, 0, 1, 1, '0);

        // Back-to-back fill past capacity, then drain in order.
        for (int i = 0; i < DEPTH + 3; i++) cycle(0, 1, 1, 0, 0, 32'(i));
        for (int i = 0; i < DEPTH + 4; i++) cycle(0, 0, 0, 1, 1, '0);

        // Steady push+pop at occupancy 1.
        cycle(0, 1, 1, 0, 0, $urandom);
        cycle(0, 0, 0, 0, 0, '0);
        for (int i = 0; i < 100; i++) cycle(0, 1, 1, 1, 1, $urandom);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1, '0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < DEPTH + 3; i++) cycle(0, 1, 1, 0, 0, $urandom);
        cycle(0, 1, 1, 1, 1, $urandom);
        cycle(0, 0, 0, 0, 0, '0);
        for (int i = 0; i < DEPTH + 4; i++) cycle(0, 0, 0, 1, 1, '0);

        // Reset with data queued and push held.
        for (int i = 0; i < 8; i++) cycle(0, 1, 1, 0, 0, $urandom);
        cycle(1, 1, 1, 0, 0, $urandom);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1, 1, '0);

        // Random traffic with alternating write pressure and rare resets.
        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < 80; i++) begin
                int wp;
                wp = (blk % 2 == 1) ? 80 : 30;
                cycle(($urandom_range(0, 199) == 0),
                      ($urandom_range(0, 9) != 0), ($urandom_range(0, 99) < wp),
                      ($urandom_range(0, 9) != 0), ($urandom_range(0, 99) < 55),
                      $urandom);
            end
        end
        for (int i = 0; i < DEPTH + 4; i++) cycle(0, 0, 0, 1, 1, '0);
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
